spi_xfer_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one SPI byte-transfer engine (the SCK divider / MOSI-MISO shift datapath) among up to N_REQ requesters. It grants one requester at a time and owns chip-select. Each transaction sends an address byte, then clocks in a programmed number of read bytes, and enforces a minimum CS-deasserted gap between transactions. It sits between the client blocks (ROM loaders, UART bridge) and the SPI engine.

---
 rtl/spi_xfer_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin arbiter and transaction sequencer that shares one
// SPI byte engine among N_REQ requesters and owns chip-select.
// Each transaction sends one address byte, then clocks in len read bytes (tx 8'h00).
// Optional feature macro: ARB_TIMEOUT_EN enables a per-byte engine watchdog driving o_err;
// without it o_err is tied low and WAIT waits indefinitely.
//
// state | meaning
// IDLE  | CS high, pick round-robin winner when any request is present
// GRANT | latch winner address/len, raise grant, pull CS low
// SEND  | pulse engine start with the tx byte
// WAIT  | wait for engine byte done (or watchdog expiry)
// GAP   | CS high, done pulsed on entry, hold CS_GAP cycles
module spi_xfer_arbiter #(
    parameter int          N_REQ   = 4,
    parameter int          CS_GAP  = 5,
    parameter logic [15:0] TIMEOUT = 16'd60000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [8*N_REQ-1:0] i_req_addr,
    input  logic [4*N_REQ-1:0] i_req_len,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [7:0]         o_rx_data,
    output logic               o_rx_valid,
    output logic [N_REQ-1:0]   o_done,
    output logic               o_err,
    output logic               o_cs_n,
    output logic               o_eng_start,
    output logic [7:0]         o_eng_byte,
    input  logic               i_eng_done,
    input  logic [7:0]         i_eng_rx
);

    localparam int                IW       = $clog2(N_REQ);
    localparam logic [IW-1:0]     LAST_RST = IW'(N_REQ - 1);
    localparam logic [3:0]        GAP_LOAD = 4'(CS_GAP);
    localparam logic [N_REQ-1:0]  ONE_HOT0 = N_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    state_t        state, state_nx;
    logic [IW-1:0] gnt_idx;      // doubles as last_gnt for the round-robin search
    logic [IW-1:0] winner;
    logic [IW-1:0] cand;
    logic          any_req;
    logic [7:0]    tx_byte;
    logic [3:0]    byte_cnt;
    logic [3:0]    gap_cnt;
    logic          addr_phase;
    logic          more;
    logic          wd_fire;

    // After the address byte, any nonzero count means data follows; after a data
    // byte the count is decremented, so one remaining means this was the last.
    assign more = addr_phase ? (byte_cnt != 4'd0) : (byte_cnt != 4'd1);

    // Round-robin search starting one past the last grant, wrapping modulo N_REQ.
    always_comb begin
        winner  = gnt_idx;
        cand    = gnt_idx;
        any_req = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(gnt_idx) + i) % N_REQ);
            if (!any_req && i_req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign wd_fire = (wd_cnt == 16'd0);

    // Watchdog down-counter: reloaded on each engine start, runs while waiting for the byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt <= 16'd0;
            o_err  <= 1'b0;
        end else begin
            o_err <= (state == S_WAIT) && !i_eng_done && wd_fire;
            if (state == S_SEND) begin
                wd_cnt <= TIMEOUT - 16'd1;
            end else if (state == S_WAIT && !wd_fire) begin
                wd_cnt <= wd_cnt - 16'd1;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign o_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (any_req) state_nx = S_GRANT;
            S_GRANT: state_nx = S_SEND;
            S_SEND:  state_nx = S_WAIT;
            S_WAIT: begin
                if (i_eng_done) begin
                    state_nx = more ? S_SEND : S_GAP;
                end else if (wd_fire) begin
                    state_nx = S_GAP;
                end
            end
            S_GAP:   if (gap_cnt == 4'd1) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Registered datapath and outputs, advanced according to the current state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gnt_idx     <= LAST_RST;
            tx_byte     <= 8'h00;
            byte_cnt    <= 4'd0;
            gap_cnt     <= 4'd0;
            addr_phase  <= 1'b0;
            o_gnt       <= '0;
            o_rx_data   <= 8'h00;
            o_rx_valid  <= 1'b0;
            o_done      <= '0;
            o_cs_n      <= 1'b1;
            o_eng_start <= 1'b0;
            o_eng_byte  <= 8'h00;
        end else begin
            o_rx_valid  <= 1'b0;
            o_done      <= '0;
            o_eng_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) gnt_idx <= winner;
                end
                S_GRANT: begin
                    o_gnt      <= ONE_HOT0 << gnt_idx;
                    o_cs_n     <= 1'b0;
                    tx_byte    <= i_req_addr[{gnt_idx, 3'b000} +: 8];
                    byte_cnt   <= i_req_len[{gnt_idx, 2'b00} +: 4];
                    addr_phase <= 1'b1;
                end
                S_SEND: begin
                    o_eng_start <= 1'b1;
                    o_eng_byte  <= tx_byte;
                end
                S_WAIT: begin
                    if (i_eng_done) begin
                        addr_phase <= 1'b0;
                        if (!addr_phase) begin
                            o_rx_data  <= i_eng_rx;
                            o_rx_valid <= 1'b1;
                            byte_cnt   <= byte_cnt - 4'd1;
                        end
                        if (more) begin
                            tx_byte <= 8'h00;
                        end else begin
                            o_gnt   <= '0;
                            o_cs_n  <= 1'b1;
                            o_done  <= o_gnt;
                            gap_cnt <= GAP_LOAD;
                        end
                    end else if (wd_fire) begin
                        o_gnt   <= '0;
                        o_cs_n  <= 1'b1;
                        o_done  <= o_gnt;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Testbench for spi_xfer_arbiter: table-driven transactions plus hand-written
// sequences for latency, mid-transaction arrivals, reset in WAIT and (with
// ARB_TIMEOUT_EN) the engine watchdog.
module tb_spi_xfer_arbiter;

    localparam int N_REQ   = 4;
    localparam int CS_GAP  = 5;
    localparam int ENG_LAT = 2;
`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TB_TO = 16'd100;
`else
    localparam logic [15:0] TB_TO = 16'd60000;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N_REQ-1:0]    req = '0;
    logic [8*N_REQ-1:0]  req_addr = '0;
    logic [4*N_REQ-1:0]  req_len = '0;
    logic [N_REQ-1:0]    gnt;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [N_REQ-1:0]    done;
    logic                err;
    logic                cs_n;
    logic                eng_start;
    logic [7:0]          eng_byte;
    logic                eng_done = 1'b0;
    logic [7:0]          eng_rx = 8'h00;
    logic                eng_en = 1'b1;

    int checks = 0;
    int errors = 0;

    // monitor state
    int cyc = 0, ed_cyc = -100;
    int n_start = 0, n_rx = 0, n_done = 0, n_err = 0;
    int st_idx = 0, rx_k = 0;
    int first_byte = 0, last_rx = 0, done_idx = -1;
    int byte_err = 0, oh_err = 0, lat_err = 0, seq_err = 0;
    int hi_run = 0, min_gap = 999, after_done = 0;
    int start_cyc = 0, err_cyc = 0, done_cyc = 0;

    spi_xfer_arbiter #(.N_REQ(N_REQ), .CS_GAP(CS_GAP), .TIMEOUT(TB_TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_addr(req_addr), .i_req_len(req_len),
        .o_gnt(gnt), .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_done(done), .o_err(err),
        .o_cs_n(cs_n), .o_eng_start(eng_start), .o_eng_byte(eng_byte),
        .i_eng_done(eng_done), .i_eng_rx(eng_rx)
    );

    always #5 clk = ~clk;

    // SPI engine model: done ENG_LAT cycles after start; address byte returns EE,
    // data byte k returns k*8'h11.
    initial begin
        int e_idx;
        e_idx = 0;
        forever begin
            @(posedge clk); #2;
            if (cs_n) e_idx = 0;
            if (eng_en && eng_start && rst_n) begin
                repeat (ENG_LAT) begin @(posedge clk); #2; end
                eng_rx   = (e_idx == 0) ? 8'hEE : 8'(e_idx * 17);
                eng_done = 1'b1;
                e_idx++;
                @(posedge clk); #2;
                eng_done = 1'b0;
                eng_rx   = 8'h00;
            end
        end
    end

    // Output monitor sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (eng_start) begin
                n_start++;
                start_cyc = cyc;
                if (st_idx == 0) first_byte = int'(eng_byte);
                else begin
                    if (eng_byte != 8'h00) byte_err++;
                    if (cyc - ed_cyc != 2) lat_err++;
                end
                st_idx++;
            end
            if (rx_valid) begin
                n_rx++;
                rx_k++;
                last_rx = int'(rx_data);
                if (rx_data != 8'(rx_k * 17)) seq_err++;
                if (cyc - ed_cyc != 1) lat_err++;
            end
            if (done != '0) begin
                n_done++;
                done_cyc = cyc;
                after_done = 1;
                if (!$onehot(done)) oh_err++;
                for (int k = 0; k < N_REQ; k++) if (done[k]) done_idx = k;
            end
            if (gnt != '0 && !$onehot(gnt)) oh_err++;
            if (err) begin n_err++; err_cyc = cyc; end
            if (cs_n) begin
                hi_run++;
                st_idx = 0;
                rx_k = 0;
            end else begin
                if (after_done != 0 && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                after_done = 0;
                hi_run = 0;
            end
            if (eng_done) ed_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_all(input logic [7:0] addr, input logic [3:0] len);
        for (int k = 0; k < N_REQ; k++) begin
            req_addr[8*k +: 8] = addr ^ 8'(k);
            req_len[4*k +: 4]  = len;
        end
    endtask

    task automatic wait_done(output int idx);
        int base;
        base = n_done;
        for (int c = 0; c < 3000 && n_done == base; c++) tick();
        if (n_done == base) begin
            chk("done_timeout", 0, 1);
            idx = -1;
        end else begin
            idx = done_idx;
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [7:0] addr;
        logic [3:0] len;
        int         exp_win;
        int         exp_byte;
        int         exp_rx;
        int         exp_last;
    } row_t;

    row_t rows[9];

    initial begin
        int w, s0, r0, d0;
        rows[0] = '{4'b0001, 8'hA5, 4'd2,  0, 'hA5, 2,  'h22};
        rows[1] = '{4'b1111, 8'hA0, 4'd0,  1, 'hA1, 0,  0};
        rows[2] = '{4'b1111, 8'hA0, 4'd0,  2, 'hA2, 0,  0};
        rows[3] = '{4'b1111, 8'hA0, 4'd0,  3, 'hA3, 0,  0};
        rows[4] = '{4'b1111, 8'hA0, 4'd0,  0, 'hA0, 0,  0};
        rows[5] = '{4'b0100, 8'h30, 4'd1,  2, 'h32, 1,  'h11};
        rows[6] = '{4'b1010, 8'h30, 4'd1,  3, 'h33, 1,  'h11};
        rows[7] = '{4'b0010, 8'h30, 4'd1,  1, 'h31, 1,  'h11};
        rows[8] = '{4'b0001, 8'h5A, 4'd15, 0, 'h5A, 15, 'hFF};

        // reset values
        tick(); tick();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_strobes", int'({rx_valid, eng_start, err}), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_data", int'({rx_data, eng_byte}), 0);
        rst_n = 1'b1;
        tick();

        // request-to-grant latency: grant two cycles after req, start one after that
        set_all(8'h77, 4'd0);
        req = 4'b0001;
        tick();
        chk("lat_gnt_early", int'(gnt), 0);
        tick();
        chk("lat_gnt", int'(gnt), 1);
        chk("lat_cs_low", int'(cs_n), 0);
        chk("lat_start_early", int'(eng_start), 0);
        tick();
        chk("lat_start", int'(eng_start), 1);
        chk("lat_byte", int'(eng_byte), 'h77);
        wait_done(w);
        req = '0;
        chk("lat_done_idx", w, 0);

        // table-driven transactions
        for (int r = 0; r < 9; r++) begin
            s0 = n_start; r0 = n_rx; d0 = n_done;
            set_all(rows[r].addr, rows[r].len);
            req = rows[r].mask;
            wait_done(w);
            req = '0;
            chk($sformatf("row%0d_win", r), w, rows[r].exp_win);
            chk($sformatf("row%0d_starts", r), n_start - s0, int'(rows[r].len) + 1);
            chk($sformatf("row%0d_addr", r), first_byte, rows[r].exp_byte);
            chk($sformatf("row%0d_rxcnt", r), n_rx - r0, rows[r].exp_rx);
            if (rows[r].exp_rx > 0) chk($sformatf("row%0d_rxlast", r), last_rx, rows[r].exp_last);
            chk($sformatf("row%0d_ndone", r), n_done - d0, 1);
        end

        // requests arriving mid-transaction; granted requester drops early
        set_all(8'h40, 4'd1);
        req = 4'b0100;
        for (int c = 0; c < 200 && gnt[2] !== 1'b1; c++) tick();
        chk("mid_gnt2", int'(gnt), 'b0100);
        req = 4'b1010;
        r0 = n_rx;
        wait_done(w);
        chk("mid_first", w, 2);
        chk("mid_drop_rx", n_rx - r0, 1);
        wait_done(w);
        req = 4'b0010;
        chk("mid_second", w, 3);
        wait_done(w);
        req = '0;
        chk("mid_third", w, 1);

        // reset while waiting on the engine
        set_all(8'h55, 4'd3);
        req = 4'b0001;
        s0 = n_start;
        for (int c = 0; c < 200 && n_start == s0; c++) tick();
        chk("rstw_started", n_start - s0, 1);
        rst_n = 1'b0;
        #1;
        chk("rstw_cs_n", int'(cs_n), 1);
        chk("rstw_gnt", int'(gnt), 0);
        req = '0;
        r0 = n_rx;
        tick(); tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("rstw_no_rx", n_rx - r0, 0);
        set_all(8'h60, 4'd0);
        req = 4'b1111;
        wait_done(w);
        req = '0;
        chk("rstw_first_win", w, 0);

`ifdef ARB_TIMEOUT_EN
        // silent engine: err and done exactly TIMEOUT cycles after start
        eng_en = 1'b0;
        set_all(8'h20, 4'd2);
        r0 = n_rx; d0 = n_err;
        req = 4'b0010;
        wait_done(w);
        req = '0;
        chk("to_idx", w, 1);
        chk("to_nerr", n_err - d0, 1);
        chk("to_delay", err_cyc - start_cyc, 100);
        chk("to_done_with_err", done_cyc, err_cyc);
        chk("to_no_rx", n_rx - r0, 0);
        eng_en = 1'b1;
        repeat (8) tick();
        req = 4'b0001;
        wait_done(w);
        req = '0;
        chk("to_next_win", w, 0);
`else
        chk("no_err_pulses", n_err, 0);
`endif

        repeat (10) tick();
        chk("gnt_done_onehot", oh_err, 0);
        chk("data_bytes_zero", byte_err, 0);
        chk("strobe_latency", lat_err, 0);
        chk("rx_sequence", seq_err, 0);
        chk("cs_gap_min_ok", int'(min_gap >= CS_GAP + 1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
